gray_frame_sequencer: RTL and testbench

Frame-level controller for the RGB-to-grayscale conversion stage of the Sobel pipeline. Arms on a software/top-level start, waits for camera frame sync, gates the converter's per-pixel enable for exactly one IMG_W x IMG_H frame, and emits pixel coordinates, end-of-line/end-of-frame markers and a valid strobe aligned to the converter's registered output. Sits between the camera capture interface and the grayscale converter; its outputs feed the Sobel line buffers.

---
 rtl/gray_frame_sequencer.sv | 164 ++++++++++++++++
 tb/tb_gray_frame_sequencer.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/gray_frame_sequencer.sv
// Frame-level controller for the RGB-to-grayscale stage. It gates the converter enable for one
// IMG_W x IMG_H frame and delays pixel coordinates and markers to match the converter output.
module gray_frame_sequencer #(
  parameter int IMG_W = 320,
  parameter int IMG_H = 240,
  parameter int LAT   = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start_i,
  input  logic                     continuous_i,
  input  logic                     cam_vsync_i,
  input  logic                     cam_valid_i,
  output logic                     conv_en_o,
  output logic                     gray_valid_o,
  output logic [$clog2(IMG_W)-1:0] col_o,
  output logic [$clog2(IMG_H)-1:0] row_o,
  output logic                     eol_o,
  output logic                     eof_o,
  output logic                     busy_o,
  output logic                     frame_done_o,
  output logic                     short_frame_o,
  output logic                     overrun_o
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);

  typedef enum logic [2:0] {IDLE, ARMED, CAPTURE, DRAIN, DONE} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] col_cnt, col_nxt, acc_col;
  logic [RW-1:0] row_cnt, row_nxt, acc_row;
  logic [2:0]    drain_cnt, drain_nxt;
  logic          accept, acc_eol, acc_eof;
  logic          short_frame_set, overrun_set;

  logic [LAT-1:0] v_sr, eol_sr, eof_sr;
  logic [CW-1:0]  col_sr [LAT];
  logic [RW-1:0]  row_sr [LAT];

  // A vsync inside CAPTURE restarts the frame, so a coincident pixel becomes (0,0).
  always_comb begin
    state_nxt       = state;
    col_nxt         = col_cnt;
    row_nxt         = row_cnt;
    drain_nxt       = drain_cnt;
    accept          = 1'b0;
    acc_col         = col_cnt;
    acc_row         = row_cnt;
    acc_eol         = 1'b0;
    acc_eof         = 1'b0;
    short_frame_set = 1'b0;
    overrun_set     = 1'b0;
    case (state)
      IDLE: begin
        if (start_i) state_nxt = ARMED;
      end
      ARMED: begin
        if (cam_vsync_i) begin
          state_nxt = CAPTURE;
          col_nxt   = '0;
          row_nxt   = '0;
        end
      end
      CAPTURE: begin
        if (cam_vsync_i) begin
          short_frame_set = 1'b1;
          acc_col         = '0;
          acc_row         = '0;
          col_nxt         = '0;
          row_nxt         = '0;
        end
        accept  = cam_valid_i;
        acc_eol = (acc_col == CW'(IMG_W - 1));
        acc_eof = acc_eol && (acc_row == RW'(IMG_H - 1));
        if (accept) begin
          if (acc_eof) begin
            state_nxt = DRAIN;
            drain_nxt = '0;
            col_nxt   = '0;
            row_nxt   = '0;
          end else if (acc_eol) begin
            col_nxt = '0;
            row_nxt = acc_row + RW'(1);
          end else begin
            col_nxt = acc_col + CW'(1);
          end
        end
      end
      DRAIN: begin
        overrun_set = cam_valid_i;
        if (drain_cnt == 3'(LAT - 1)) state_nxt = DONE;
        else drain_nxt = drain_cnt + 3'd1;
      end
      DONE: begin
        state_nxt = continuous_i ? ARMED : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign conv_en_o    = accept;
  assign busy_o       = (state != IDLE);
  assign frame_done_o = (state == DONE);

  // Sticky flags: a set in the same cycle as a start-clear takes priority.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      col_cnt       <= '0;
      row_cnt       <= '0;
      drain_cnt     <= '0;
      short_frame_o <= 1'b0;
      overrun_o     <= 1'b0;
    end else begin
      state     <= state_nxt;
      col_cnt   <= col_nxt;
      row_cnt   <= row_nxt;
      drain_cnt <= drain_nxt;
      if (short_frame_set) short_frame_o <= 1'b1;
      else if (start_i)    short_frame_o <= 1'b0;
      if (overrun_set)     overrun_o <= 1'b1;
      else if (start_i)    overrun_o <= 1'b0;
    end
  end

  // Coordinates only advance with a valid entry so the tail holds the last pixel's position.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_sr   <= '0;
      eol_sr <= '0;
      eof_sr <= '0;
      for (int i = 0; i < LAT; i++) begin
        col_sr[i] <= '0;
        row_sr[i] <= '0;
      end
    end else begin
      for (int i = LAT - 1; i > 0; i--) begin
        v_sr[i]   <= v_sr[i-1];
        eol_sr[i] <= eol_sr[i-1];
        eof_sr[i] <= eof_sr[i-1];
        if (v_sr[i-1]) begin
          col_sr[i] <= col_sr[i-1];
          row_sr[i] <= row_sr[i-1];
        end
      end
      v_sr[0]   <= accept;
      eol_sr[0] <= accept && acc_eol;
      eof_sr[0] <= accept && acc_eof;
      if (accept) begin
        col_sr[0] <= acc_col;
        row_sr[0] <= acc_row;
      end
    end
  end

  assign gray_valid_o = v_sr[LAT-1];
  assign eol_o        = eol_sr[LAT-1];
  assign eof_o        = eof_sr[LAT-1];
  assign col_o        = col_sr[LAT-1];
  assign row_o        = row_sr[LAT-1];

endmodule

// File: tb/tb_gray_frame_sequencer.sv
// Bench for gray_frame_sequencer: a LAT=1 and a LAT=3 instance share one 4x2 stimulus stream,
// and a scoreboard queue per instance holds the expected output pixels.
module tb_gray_frame_sequencer;

  localparam int W = 4;
  localparam int H = 2;

  logic clk = 1'b0, rst = 1'b1;
  logic start_i = 1'b0, continuous_i = 1'b0, cam_vsync_i = 1'b0, cam_valid_i = 1'b0;

  logic conv_en1, gv1, eol1, eof1, busy1, done1, short1, over1;
  logic [1:0] col1;
  logic [0:0] row1;
  logic conv_en3, gv3, eol3, eof3, busy3, done3, short3, over3;
  logic [1:0] col3;
  logic [0:0] row3;

  always #5 clk = ~clk;

  gray_frame_sequencer #(.IMG_W(W), .IMG_H(H), .LAT(1)) dut1 (
    .clk(clk), .rst(rst), .start_i(start_i), .continuous_i(continuous_i),
    .cam_vsync_i(cam_vsync_i), .cam_valid_i(cam_valid_i), .conv_en_o(conv_en1),
    .gray_valid_o(gv1), .col_o(col1), .row_o(row1), .eol_o(eol1), .eof_o(eof1),
    .busy_o(busy1), .frame_done_o(done1), .short_frame_o(short1), .overrun_o(over1)
  );

  gray_frame_sequencer #(.IMG_W(W), .IMG_H(H), .LAT(3)) dut3 (
    .clk(clk), .rst(rst), .start_i(start_i), .continuous_i(continuous_i),
    .cam_vsync_i(cam_vsync_i), .cam_valid_i(cam_valid_i), .conv_en_o(conv_en3),
    .gray_valid_o(gv3), .col_o(col3), .row_o(row3), .eol_o(eol3), .eof_o(eof3),
    .busy_o(busy3), .frame_done_o(done3), .short_frame_o(short3), .overrun_o(over3)
  );

  typedef struct {
    int   cyc;
    int   col;
    int   row;
    logic eol;
    logic eof;
  } pix_t;

  pix_t q1[$];
  pix_t q3[$];
  pix_t e1, e3;

  int cyc = 0, total = 0, bad = 0;
  int done1_cnt = 0, done3_cnt = 0, done1_cyc = -1, done3_cyc = -1;
  int mcol = 0, mrow = 0, last_acc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Output side of the scoreboard: each valid pixel must match the oldest expected entry.
  always @(negedge clk) begin
    if (gv1) begin
      check_output("dut1_pending", q1.size() > 0, 1);
      if (q1.size() > 0) begin
        e1 = q1.pop_front();
        check_output("dut1_latency", cyc, e1.cyc + 1);
        check_output("dut1_pixel", {col1, row1, eol1, eof1},
                     {e1.col[1:0], e1.row[0:0], e1.eol, e1.eof});
      end
    end
    if (gv3) begin
      check_output("dut3_pending", q3.size() > 0, 1);
      if (q3.size() > 0) begin
        e3 = q3.pop_front();
        check_output("dut3_latency", cyc, e3.cyc + 3);
        check_output("dut3_pixel", {col3, row3, eol3, eof3},
                     {e3.col[1:0], e3.row[0:0], e3.eol, e3.eof});
      end
    end
    if (done1) begin done1_cnt++; done1_cyc = cyc; end
    if (done3) begin done3_cnt++; done3_cyc = cyc; end
  end

  task automatic apply_stimulus(input logic st, input logic vs, input logic val, input logic acc);
    pix_t p;
    @(negedge clk);
    start_i     = st;
    cam_vsync_i = vs;
    cam_valid_i = val;
    if (vs) begin mcol = 0; mrow = 0; end
    #1;
    check_output("conv_en1", conv_en1, acc);
    check_output("conv_en3", conv_en3, acc);
    if (acc) begin
      p.cyc = cyc;
      p.col = mcol;
      p.row = mrow;
      p.eol = (mcol == W - 1);
      p.eof = (mcol == W - 1) && (mrow == H - 1);
      q1.push_back(p);
      q3.push_back(p);
      last_acc = cyc;
      if (mcol == W - 1) begin mcol = 0; mrow = (mrow + 1) % H; end
      else mcol++;
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic check_frame_end(input int n_done);
    check_output("done1_cycle", done1_cyc, last_acc + 2);
    check_output("done3_cycle", done3_cyc, last_acc + 4);
    check_output("done1_count", done1_cnt, n_done);
    check_output("done3_count", done3_cnt, n_done);
  endtask

  initial begin
    $display("[TB] gray_frame_sequencer bench start");
    @(negedge clk);
    @(negedge clk);
    #1;
    check_output("reset_dut1", {conv_en1, gv1, col1, row1, eol1, eof1, busy1, done1, short1, over1}, 0);
    check_output("reset_dut3", {conv_en3, gv3, col3, row3, eol3, eof3, busy3, done3, short3, over3}, 0);
    rst = 1'b0;

    // Back-to-back frame
    apply_stimulus(1, 0, 0, 0);
    apply_stimulus(0, 1, 0, 0);
    check_output("busy_armed", {busy1, busy3}, 2'b11);
    for (int i = 0; i < 8; i++) apply_stimulus(0, 0, 1, 1);
    idle_cycles(5);
    check_frame_end(1);
    check_output("busy_after", {busy1, busy3}, 2'b00);
    check_output("hold_dut1", {gv1, col1, row1}, {1'b0, 2'd3, 1'b1});
    check_output("hold_dut3", {gv3, col3, row3}, {1'b0, 2'd3, 1'b1});

    // Sparse pixels with pre-vsync pixels ignored
    apply_stimulus(1, 0, 0, 0);
    apply_stimulus(0, 0, 1, 0);
    apply_stimulus(0, 0, 1, 0);
    apply_stimulus(0, 1, 0, 0);
    for (int i = 0; i < 8; i++) begin
      apply_stimulus(0, 0, 1, 1);
      idle_cycles(2);
    end
    idle_cycles(3);
    check_frame_end(2);
    check_output("no_flags", {short1, over1, short3, over3}, 0);

    // Short frame: vsync with a coincident pixel after 5 pixels
    apply_stimulus(1, 0, 0, 0);
    apply_stimulus(0, 1, 0, 0);
    for (int i = 0; i < 5; i++) apply_stimulus(0, 0, 1, 1);
    apply_stimulus(0, 1, 1, 1);
    for (int i = 0; i < 7; i++) apply_stimulus(0, 0, 1, 1);
    idle_cycles(5);
    check_frame_end(3);
    check_output("short_set", {short1, short3}, 2'b11);
    apply_stimulus(1, 0, 0, 0);
    apply_stimulus(0, 0, 0, 0);
    check_output("short_clear", {short1, short3}, 2'b00);

    // Overrun: pixel right after the last pixel lands in DRAIN
    apply_stimulus(0, 1, 0, 0);
    for (int i = 0; i < 8; i++) apply_stimulus(0, 0, 1, 1);
    apply_stimulus(0, 0, 1, 0);
    idle_cycles(5);
    check_frame_end(4);
    check_output("overrun_set", {over1, over3}, 2'b11);

    // Continuous mode: two frames, busy never drops
    continuous_i = 1'b1;
    apply_stimulus(1, 0, 0, 0);
    apply_stimulus(0, 1, 0, 0);
    check_output("overrun_clear", {over1, over3}, 2'b00);
    for (int i = 0; i < 8; i++) apply_stimulus(0, 0, 1, 1);
    for (int i = 0; i < 6; i++) begin
      apply_stimulus(0, 0, 0, 0);
      check_output("busy_cont", {busy1, busy3}, 2'b11);
    end
    check_frame_end(5);
    apply_stimulus(0, 1, 0, 0);
    for (int i = 0; i < 8; i++) apply_stimulus(0, 0, 1, 1);
    for (int i = 0; i < 6; i++) begin
      apply_stimulus(0, 0, 0, 0);
      check_output("busy_cont", {busy1, busy3}, 2'b11);
    end
    check_frame_end(6);
    continuous_i = 1'b0;

    // Reset in row 1 discards in-flight pixels and suppresses frame_done
    apply_stimulus(0, 1, 0, 0);
    for (int i = 0; i < 6; i++) apply_stimulus(0, 0, 1, 1);
    @(negedge clk);
    cam_valid_i = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check_output("midreset_dut1", {conv_en1, gv1, col1, row1, eol1, eof1, busy1, done1, short1, over1}, 0);
    check_output("midreset_dut3", {conv_en3, gv3, col3, row3, eol3, eof3, busy3, done3, short3, over3}, 0);
    q1.delete();
    q3.delete();
    idle_cycles(2);
    rst = 1'b0;
    idle_cycles(4);
    check_output("reset_no_done1", done1_cnt, 6);
    check_output("reset_no_done3", done3_cnt, 6);
    apply_stimulus(1, 0, 0, 0);
    apply_stimulus(0, 1, 0, 0);
    for (int i = 0; i < 8; i++) apply_stimulus(0, 0, 1, 1);
    idle_cycles(5);
    check_frame_end(7);

    check_output("q1_drained", q1.size(), 0);
    check_output("q3_drained", q3.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
